// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled rx line, centre-of-bit sampling, valid/ack
// holding register with framing-error pulse and sticky overrun flag.
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int baud     = 9600
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_err,
    output logic       overrun,
    output logic       bsy
);

    localparam int N    = CLK_FREQ / baud;
    localparam int HALF = N / 2;
    localparam int CW   = $clog2(N) + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_next;
    logic [1:0]    rst_q;
    logic          rst_n_i;
    logic [1:0]    rx_q;
    logic          rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          cnt_clr, shift_en, frame_ok, frame_bad;
    logic          half_hit, cnt_last;

    // Assert asynchronously, release two clocks after rst goes high.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) rst_q <= '0;
        else      rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n_i = rst_q[1];

    always_ff @(posedge clk_in or negedge rst_n_i) begin
        if (!rst_n_i) rx_q <= '1;
        else          rx_q <= {rx_q[0], rx};
    end
    assign rx_s = rx_q[1];

    assign half_hit = (clk_cnt == CW'(HALF - 1));
    assign cnt_last = (clk_cnt == CW'(N - 1));
    assign bsy      = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_clr    = 1'b1;
                end
            end
            START: begin
                if (half_hit) begin
                    cnt_clr    = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        frame_ok   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            clk_cnt <= cnt_clr ? '0 : clk_cnt + CW'(1);
            if (state != DATA)  bit_cnt <= '0;
            else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg <= {rx_s, shreg[7:1]};
        end
    end

    // A completing frame takes priority over a same-cycle ack; the ack then
    // only suppresses the overrun flag.
    always_ff @(posedge clk_in or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data        <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            if (frame_ok) begin
                data       <= shreg;
                data_valid <= 1'b1;
                overrun    <= data_valid && !rd_ack;
            end else if (rd_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 115200 baud on a 50 MHz clock.
module tb_uart_rx;

    localparam int N    = 50000000 / 115200;  // 434
    localparam int HALF = N / 2;              // 217
    localparam int RISE = 3 + HALF + 9 * N;   // negedges from rx fall to data_valid seen high

    logic       clk_in = 1'b0;
    logic       rst    = 1'b0;
    logic       rx     = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] data;
    logic       data_valid, framing_err, overrun, bsy;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx #(.CLK_FREQ(50000000), .baud(115200)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .rx          (rx),
        .rd_ack      (rd_ack),
        .data        (data),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .overrun     (overrun),
        .bsy         (bsy)
    );

    always #10 clk_in = ~clk_in;

    // Drives one frame starting at a negedge; ack_at/abort_at index negedges (-1 = never).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int ack_at, input int abort_at,
                              output int rise_at, output int fe_cnt);
        logic [9:0] fr;
        logic       dv0;
        int         k;
        fr      = {stop_bit, b, 1'b0};
        dv0     = data_valid;
        k       = 0;
        rise_at = -1;
        fe_cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (N) begin
                if (k == abort_at) begin
                    rd_ack = 1'b0;
                    return;
                end
                rd_ack = (k == ack_at);
                @(negedge clk_in);
                k++;
                if (!dv0 && rise_at < 0 && data_valid) rise_at = k;
                if (framing_err) fe_cnt++;
            end
        end
        rd_ack = 1'b0;
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        @(negedge clk_in);
        rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        int hits;
        rst = 1'b0; rx = 1'b1; rd_ack = 1'b0;
        repeat (5) @(negedge clk_in);
        n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %0h expected 0", data); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dv: got %0b expected 0", data_valid); end
        n_cmp++; if (framing_err !== 1'b0) begin n_bad++; $display("FAIL reset_fe: got %0b expected 0", framing_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ov: got %0b expected 0", overrun); end
        n_cmp++; if (bsy !== 1'b0) begin n_bad++; $display("FAIL reset_bsy: got %0b expected 0", bsy); end
        rst  = 1'b1;
        hits = 0;
        repeat (10000) begin
            @(negedge clk_in);
            if (bsy || data_valid || framing_err || overrun) hits++;
        end
        n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL idle_quiet: got %0d active cycles expected 0", hits); end
    endtask

    task automatic test_rx_a5();
        int rise, fe, drops;
        send_frame(8'hA5, 1'b1, -1, -1, rise, fe);
        n_cmp++; if (rise !== RISE) begin n_bad++; $display("FAIL a5_latency: got %0d expected %0d", rise, RISE); end
        n_cmp++; if (data !== 8'hA5) begin n_bad++; $display("FAIL a5_data: got %0h expected a5", data); end
        n_cmp++; if (fe !== 0) begin n_bad++; $display("FAIL a5_fe: got %0d pulses expected 0", fe); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL a5_ov: got %0b expected 0", overrun); end
        n_cmp++; if (bsy !== 1'b0) begin n_bad++; $display("FAIL a5_bsy: got %0b expected 0", bsy); end
        drops = 0;
        repeat (100) begin
            @(negedge clk_in);
            if (!data_valid) drops++;
        end
        n_cmp++; if (drops !== 0) begin n_bad++; $display("FAIL a5_hold: got %0d dropped cycles expected 0", drops); end
        pulse_ack();
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL a5_ack: got %0b expected 0", data_valid); end
        pulse_ack();
        n_cmp++; if ({data_valid, overrun, data} !== {2'b00, 8'hA5}) begin
            n_bad++; $display("FAIL idle_ack: got %0h expected a5", {data_valid, overrun, data}); end
    endtask

    task automatic test_glitch();
        int fe, dv, seen_bsy;
        rx = 1'b0;
        repeat (100) @(negedge clk_in);
        rx = 1'b1;
        seen_bsy = bsy;
        fe = 0; dv = 0;
        repeat (300) begin
            @(negedge clk_in);
            if (framing_err) fe++;
            if (data_valid) dv++;
        end
        n_cmp++; if (seen_bsy !== 1) begin n_bad++; $display("FAIL glitch_start: got bsy %0d expected 1", seen_bsy); end
        n_cmp++; if (bsy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got bsy %0b expected 0", bsy); end
        n_cmp++; if ((fe + dv) !== 0) begin n_bad++; $display("FAIL glitch_flags: got fe %0d dv %0d expected 0 0", fe, dv); end
    endtask

    task automatic test_framing();
        int rise, fe;
        send_frame(8'h3C, 1'b0, -1, -1, rise, fe);
        n_cmp++; if (fe !== 1) begin n_bad++; $display("FAIL fe_pulse: got %0d cycles expected 1", fe); end
        n_cmp++; if (data !== 8'hA5) begin n_bad++; $display("FAIL fe_data: got %0h expected a5", data); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL fe_dv: got %0b expected 0", data_valid); end
        repeat (200) @(negedge clk_in);
        n_cmp++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL fe_break_bsy: got %0b expected 1", bsy); end
        rx = 1'b1;
        repeat (5) @(negedge clk_in);
        n_cmp++; if (bsy !== 1'b0) begin n_bad++; $display("FAIL fe_release: got %0b expected 0", bsy); end
    endtask

    task automatic test_back_to_back();
        int rise, fe;
        send_frame(8'h11, 1'b1, -1, -1, rise, fe);
        n_cmp++; if ({data_valid, overrun, data} !== {2'b10, 8'h11}) begin
            n_bad++; $display("FAIL b2b_first: got %0h expected 211", {data_valid, overrun, data}); end
        send_frame(8'h22, 1'b1, -1, -1, rise, fe);
        n_cmp++; if (data !== 8'h22) begin n_bad++; $display("FAIL b2b_data: got %0h expected 22", data); end
        n_cmp++; if ({data_valid, overrun} !== 2'b11) begin
            n_bad++; $display("FAIL b2b_flags: got %0b expected 11", {data_valid, overrun}); end
        // Ack lands in the same cycle the next byte completes.
        send_frame(8'h5A, 1'b1, RISE - 1, -1, rise, fe);
        n_cmp++; if ({data_valid, overrun, data} !== {2'b10, 8'h5A}) begin
            n_bad++; $display("FAIL ack_collide: got %0h expected 25a", {data_valid, overrun, data}); end
        pulse_ack();
        n_cmp++; if ({data_valid, overrun} !== 2'b00) begin
            n_bad++; $display("FAIL b2b_ack: got %0b expected 00", {data_valid, overrun}); end
    endtask

    task automatic test_reset_mid();
        int rise, fe;
        send_frame(8'h7E, 1'b1, -1, 5 * N + HALF, rise, fe);
        n_cmp++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %0b expected 1", bsy); end
        rst = 1'b0;
        #1;
        n_cmp++; if ({bsy, data_valid, overrun, framing_err, data} !== 12'h000) begin
            n_bad++; $display("FAIL mid_reset: got %0h expected 0", {bsy, data_valid, overrun, framing_err, data}); end
        repeat (10) @(negedge clk_in);
        rx  = 1'b1;
        rst = 1'b1;
        repeat (10) @(negedge clk_in);
        send_frame(8'h7E, 1'b1, -1, -1, rise, fe);
        n_cmp++; if (rise !== RISE) begin n_bad++; $display("FAIL 7e_latency: got %0d expected %0d", rise, RISE); end
        n_cmp++; if ({data_valid, overrun, data} !== {2'b10, 8'h7E}) begin
            n_bad++; $display("FAIL 7e_data: got %0h expected 27e", {data_valid, overrun, data}); end
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_rx_a5();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
